// File: rtl/bin2bcd_digits_if.sv
// Handshake and result bundle between a requester and bin2bcd_digits.
// start/value request a conversion; dig0..dig3, busy, done, ovf report it.
interface bin2bcd_digits_if #(
    parameter int BIN_W = 14
);
    logic             start;
    logic [BIN_W-1:0] value;
    logic [3:0]       dig0;
    logic [3:0]       dig1;
    logic [3:0]       dig2;
    logic [3:0]       dig3;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, value,
        input  dig0, dig1, dig2, dig3,
        input  busy, done, ovf
    );

    modport slave (
        input  start, value,
        output dig0, dig1, dig2, dig3,
        output busy, done, ovf
    );
endinterface

// File: rtl/bin2bcd_digits.sv
// Sequential shift-add-3 binary to 4-digit BCD converter for the 7-seg driver.
// Ports: clock, reset_n (async low), bus (slave): start/value in; dig0..3, busy, done, ovf out.
module bin2bcd_digits #(
    parameter int BIN_W = 14
) (
    input  logic clock,
    input  logic reset_n,
    bin2bcd_digits_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t state, state_nx;

    logic [BIN_W-1:0] bin_q;
    logic [15:0]      bcd_q;
    logic [15:0]      bcd_adj;
    logic [4:0]       cnt_q;
    logic             ovf_mark_q;
    logic [3:0]       dig_q [4];
    logic             done_q;
    logic             ovf_q;
    logic             in_range;

    assign in_range = 17'(bus.value) <= 17'd9999;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = in_range ? SHIFT : LOAD;
            SHIFT:   if (cnt_q == 5'd1) state_nx = LOAD;
            LOAD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Add 3 to every nibble >= 5 before the shift doubles it.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_mark_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_q      <= bus.value;
                        bcd_q      <= '0;
                        cnt_q      <= 5'(BIN_W);
                        ovf_mark_q <= !in_range;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    cnt_q          <= cnt_q - 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Result registers only move on the LOAD edge, so no partial BCD leaks out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= 4'h0;
            end
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= (state == LOAD);
            if (state == LOAD) begin
                for (int i = 0; i < 4; i++) begin
                    dig_q[i] <= ovf_mark_q ? 4'hF : bcd_q[4*i +: 4];
                end
                ovf_q <= ovf_mark_q;
            end
        end
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = done_q;
        bus.ovf  = ovf_q;
        bus.dig0 = dig_q[0];
        bus.dig1 = dig_q[1];
        bus.dig2 = dig_q[2];
        bus.dig3 = dig_q[3];
    end
endmodule

// File: tb/tb_bin2bcd_digits.sv
// Directed and random checks of bin2bcd_digits using a result scoreboard.
// Expected {ovf,dig3..dig0} is queued at each accept and popped on done.
module tb_bin2bcd_digits;
    localparam int BIN_W = 14;

    logic clock;
    logic reset_n;

    bin2bcd_digits_if #(.BIN_W(BIN_W)) bus ();

    bin2bcd_digits #(.BIN_W(BIN_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] sb_q [$];
    logic [15:0] prev_dig;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] model(input int v);
        logic [16:0] r;
        if (v > 9999) begin
            r = {1'b1, 16'hFFFF};
        end else begin
            r[16]    = 1'b0;
            r[15:12] = 4'((v / 1000) % 10);
            r[11:8]  = 4'((v / 100) % 10);
            r[7:4]   = 4'((v / 10) % 10);
            r[3:0]   = 4'(v % 10);
        end
        return r;
    endfunction

    function automatic logic [15:0] digs();
        return {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
    endfunction

    // Result monitor: pops the scoreboard on done and checks digit stability.
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_dig = digs();
        end else if (bus.done) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                chk("result", {15'd0, bus.ovf, digs()}, {15'd0, sb_q.pop_front()});
            end
            chk("busy_at_done", {31'd0, bus.busy}, 0);
            prev_dig = digs();
        end else begin
            chk("dig_stable", {16'd0, digs()}, {16'd0, prev_dig});
        end
    end

    // Drive start away from the edge; returns 1 time unit after the accept edge.
    task automatic accept(input int v);
        bus.start = 1'b1;
        bus.value = BIN_W'(v);
        sb_q.push_back(model(v));
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        chk("busy_after_accept", {31'd0, bus.busy}, 1);
    endtask

    // Counts edges until done; leaves time 1 unit after the done edge.
    task automatic wait_done(input string tag, input int lat);
        int n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!bus.done) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_latency"}, n, lat);
        end
    endtask

    task automatic conv(input int v);
        int lat;
        lat = (v > 9999) ? 1 : BIN_W + 1;
        accept(v);
        wait_done($sformatf("conv_%0d", v), lat);
    endtask

    initial begin
        int v;
        bus.start = 1'b0;
        bus.value = '0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_digs", {16'd0, digs()}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_ovf", {31'd0, bus.ovf}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // 1: basic conversion and done pulse width
        conv(1234);
        @(posedge clock);
        #1;
        chk("done_low_E16", {31'd0, bus.done}, 0);
        chk("digs_hold", {16'd0, digs()}, 32'h1234);

        // 2: boundary values
        conv(0);
        conv(9999);
        conv(10);

        // 3: overflow then recovery
        conv(10000);
        @(posedge clock);
        #1;
        chk("ovf_sticky", {31'd0, bus.ovf}, 1);
        conv(42);
        chk("ovf_cleared", {31'd0, bus.ovf}, 0);
        conv(16383);

        // 4: start while busy ignored; start during done accepted
        accept(5678);
        repeat (4) @(posedge clock);
        #1;
        bus.start = 1'b1;
        bus.value = BIN_W'(1111);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.value = BIN_W'(2222);
        wait_done("ignore_start", 10);
        accept(1111);
        chk("done_cleared_by_accept", {31'd0, bus.done}, 0);
        wait_done("back_to_back", BIN_W + 1);

        // 5: reset mid-conversion
        conv(8888);
        accept(4321);
        repeat (6) @(posedge clock);
        #2;
        reset_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        chk("abort_digs", {16'd0, digs()}, 0);
        chk("abort_busy", {31'd0, bus.busy}, 0);
        chk("abort_ovf", {31'd0, bus.ovf}, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        chk("no_done_after_abort", {31'd0, bus.done}, 0);
        chk("sb_empty_after_abort", sb_q.size(), 0);
        conv(4321);

        // 6: random sweep, back to back
        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(0, 16383));
            conv(v);
        end

        @(posedge clock);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
